// File: rtl/axi_arbiter.sv
// Two-master (instruction/data) to single AXI master bridge, one transaction in flight.
// Writes win arbitration; competing reads alternate on the last read grant.
module axi_arbiter #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    input  logic [31:0] inst_addr,
    output logic        inst_resp_valid,
    output logic [31:0] inst_resp_data,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic        data_req_wen,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_resp_valid,
    output logic [31:0] data_resp_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;   // 1: last read grant went to data
    logic        owner_data_q, owner_data_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        inst_resp_q, inst_resp_d;
    logic        data_resp_q, data_resp_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        grant_data, grant_inst;

    wire unused_ok = &{1'b0, rresp, rlast, bid, bresp};

    always_comb begin
        grant_data = data_req_valid &
                     (data_req_wen | ~(inst_req_valid & last_data_q));
        grant_inst = inst_req_valid & ~grant_data;
    end

    always_comb begin
        state_d        = state_q;
        last_data_d    = last_data_q;
        owner_data_d   = owner_data_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        inst_resp_d    = 1'b0;
        data_resp_d    = 1'b0;
        addr_d         = addr_q;
        size_d         = size_q;
        id_d           = id_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        rdata_d        = rdata_q;
        inst_req_ready = 1'b0;
        data_req_ready = 1'b0;
        arvalid        = 1'b0;
        rready         = 1'b0;
        awvalid        = 1'b0;
        wvalid         = 1'b0;
        bready         = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    data_req_ready = 1'b1;
                    addr_d         = data_addr;
                    size_d         = data_size;
                    id_d           = ID_DATA;
                    wdata_d        = data_wdata;
                    wstrb_d        = data_wstrb;
                    owner_data_d   = 1'b1;
                    if (data_req_wen) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_ADDR;
                    end else begin
                        last_data_d = 1'b1;
                        state_d     = RD_ADDR;
                    end
                end else if (grant_inst) begin
                    inst_req_ready = 1'b1;
                    addr_d         = inst_addr;
                    size_d         = 3'd2;
                    id_d           = ID_INST;
                    owner_data_d   = 1'b0;
                    last_data_d    = 1'b0;
                    state_d        = RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                // Beats carrying a foreign id are accepted and dropped.
                if (rvalid && (rid == id_q)) begin
                    rdata_d     = rdata;
                    inst_resp_d = ~owner_data_q;
                    data_resp_d = owner_data_q;
                    state_d     = IDLE;
                end
            end
            WR_ADDR: begin
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_resp_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b1;
            owner_data_q <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_resp_q  <= 1'b0;
            data_resp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            owner_data_q <= owner_data_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            inst_resp_q  <= inst_resp_d;
            data_resp_q  <= data_resp_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        size_q  <= size_d;
        id_q    <= id_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        rdata_q <= rdata_d;
    end

    assign inst_resp_valid = inst_resp_q;
    assign inst_resp_data  = rdata_q;
    assign data_resp_valid = data_resp_q;
    assign data_resp_data  = rdata_q;

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arsize  = size_q;
    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awsize  = size_q;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid   = id_q;
    assign wdata = wdata_q;
    assign wstrb = wstrb_q;
    assign wlast = 1'b1;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: the bench plays the AXI slave by hand, cycle by cycle.
module tb_axi_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_req_valid, inst_req_ready;
    logic [31:0] inst_addr;
    logic        inst_resp_valid;
    logic [31:0] inst_resp_data;
    logic        data_req_valid, data_req_ready, data_req_wen;
    logic [31:0] data_addr, data_wdata;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        data_resp_valid;
    logic [31:0] data_resp_data;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, awready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int checks = 0;
    int errors = 0;

    axi_arbiter #(.ID_INST(4'd0), .ID_DATA(4'd1)) dut (
        .clock(clock), .reset(reset),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_addr(inst_addr), .inst_resp_valid(inst_resp_valid),
        .inst_resp_data(inst_resp_data),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_wen(data_req_wen), .data_addr(data_addr), .data_size(data_size),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_resp_valid(data_resp_valid), .data_resp_data(data_resp_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow a 1-unit settle.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_wvalid",  {31'd0, wvalid},  32'd0);
        chk("rst_rready",  {31'd0, rready},  32'd0);
        chk("rst_bready",  {31'd0, bready},  32'd0);
        chk("rst_iresp",   {31'd0, inst_resp_valid}, 32'd0);
        chk("rst_dresp",   {31'd0, data_resp_valid}, 32'd0);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        inst_req_valid = 0; inst_addr = 0;
        data_req_valid = 0; data_req_wen = 0; data_addr = 0; data_size = 0;
        data_wdata = 0; data_wstrb = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        do_reset();
        chk("const_arburst", {30'd0, arburst}, 32'd1);
        chk("const_wlast", {31'd0, wlast}, 32'd1);

        // Zero-wait instruction read
        inst_req_valid = 1; inst_addr = 32'hBFC0_0000;
        settle();
        chk("t1_iready", {31'd0, inst_req_ready}, 32'd1);
        chk("t1_dready", {31'd0, data_req_ready}, 32'd0);
        tick();
        inst_req_valid = 0; arready = 1;
        settle();
        chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
        chk("t1_araddr", araddr, 32'hBFC0_0000);
        chk("t1_arid", {28'd0, arid}, 32'd0);
        chk("t1_arsize", {29'd0, arsize}, 32'd2);
        tick();
        arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h3C1D_0001;
        settle();
        chk("t1_arvalid_drop", {31'd0, arvalid}, 32'd0);
        chk("t1_rready", {31'd0, rready}, 32'd1);
        tick();
        rvalid = 0;
        settle();
        chk("t1_iresp", {31'd0, inst_resp_valid}, 32'd1);
        chk("t1_idata", inst_resp_data, 32'h3C1D_0001);
        chk("t1_dresp", {31'd0, data_resp_valid}, 32'd0);
        chk("t1_rready_idle", {31'd0, rready}, 32'd0);
        tick();
        settle();
        chk("t1_iresp_once", {31'd0, inst_resp_valid}, 32'd0);

        // Simultaneous reads straight out of reset: inst first, then data
        do_reset();
        inst_req_valid = 1; inst_addr = 32'hBFC0_0010;
        data_req_valid = 1; data_req_wen = 0; data_addr = 32'h1000_0040; data_size = 3'd1;
        settle();
        chk("t2_iready", {31'd0, inst_req_ready}, 32'd1);
        chk("t2_dready", {31'd0, data_req_ready}, 32'd0);
        tick();
        inst_req_valid = 0; arready = 1;
        settle();
        chk("t2_arid_i", {28'd0, arid}, 32'd0);
        chk("t2_dready_busy", {31'd0, data_req_ready}, 32'd0);
        tick();
        arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h1111_1111;
        tick();
        rvalid = 0;
        settle();
        chk("t2_iresp", {31'd0, inst_resp_valid}, 32'd1);
        chk("t2_idata", inst_resp_data, 32'h1111_1111);
        chk("t2_dready_idle", {31'd0, data_req_ready}, 32'd1);
        tick();
        data_req_valid = 0; arready = 1;
        settle();
        chk("t2_iresp_once", {31'd0, inst_resp_valid}, 32'd0);
        chk("t2_arid_d", {28'd0, arid}, 32'd1);
        chk("t2_arsize_d", {29'd0, arsize}, 32'd1);
        chk("t2_araddr_d", araddr, 32'h1000_0040);
        tick();
        arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h2222_2222;
        tick();
        rvalid = 0;
        settle();
        chk("t2_dresp", {31'd0, data_resp_valid}, 32'd1);
        chk("t2_ddata", data_resp_data, 32'h2222_2222);
        chk("t2_iresp_quiet", {31'd0, inst_resp_valid}, 32'd0);
        tick();
        settle();
        chk("t2_dresp_once", {31'd0, data_resp_valid}, 32'd0);

        // Write beats pending inst read; awready late, wready immediate
        data_req_valid = 1; data_req_wen = 1; data_addr = 32'h8000_1000; data_size = 3'd2;
        data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
        inst_req_valid = 1; inst_addr = 32'hBFC0_0004;
        settle();
        chk("t3_dready", {31'd0, data_req_ready}, 32'd1);
        chk("t3_iready", {31'd0, inst_req_ready}, 32'd0);
        tick();
        data_req_valid = 0; data_req_wen = 0; wready = 1;
        settle();
        chk("t3_awvalid", {31'd0, awvalid}, 32'd1);
        chk("t3_wvalid", {31'd0, wvalid}, 32'd1);
        chk("t3_awaddr", awaddr, 32'h8000_1000);
        chk("t3_awid", {28'd0, awid}, 32'd1);
        chk("t3_awsize", {29'd0, awsize}, 32'd2);
        chk("t3_wdata", wdata, 32'hDEAD_BEEF);
        chk("t3_wstrb", {28'd0, wstrb}, 32'h3);
        chk("t3_iready_w", {31'd0, inst_req_ready}, 32'd0);
        tick();
        wready = 0;
        settle();
        chk("t3_wvalid_drop", {31'd0, wvalid}, 32'd0);
        chk("t3_awvalid_hold", {31'd0, awvalid}, 32'd1);
        tick();
        settle();
        chk("t3_bready_early", {31'd0, bready}, 32'd0);
        tick();
        awready = 1;
        settle();
        chk("t3_awvalid_w4", {31'd0, awvalid}, 32'd1);
        tick();
        awready = 0;
        settle();
        chk("t3_awvalid_drop", {31'd0, awvalid}, 32'd0);
        chk("t3_bready", {31'd0, bready}, 32'd1);
        chk("t3_iready_b", {31'd0, inst_req_ready}, 32'd0);
        bvalid = 1;
        tick();
        bvalid = 0;
        settle();
        chk("t3_dresp", {31'd0, data_resp_valid}, 32'd1);
        chk("t3_bready_idle", {31'd0, bready}, 32'd0);
        chk("t3_iready_idle", {31'd0, inst_req_ready}, 32'd1);

        // Inst read with a stray beat of the wrong id
        tick();
        inst_req_valid = 0; arready = 1;
        settle();
        chk("t4_dresp_once", {31'd0, data_resp_valid}, 32'd0);
        chk("t4_araddr", araddr, 32'hBFC0_0004);
        tick();
        arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hBAD0_BAD0;
        tick();
        rid = 4'd0; rdata = 32'h0000_1234;
        settle();
        chk("t4_stray_iresp", {31'd0, inst_resp_valid}, 32'd0);
        chk("t4_stray_dresp", {31'd0, data_resp_valid}, 32'd0);
        chk("t4_rready_hold", {31'd0, rready}, 32'd1);
        tick();
        rvalid = 0;
        settle();
        chk("t4_iresp", {31'd0, inst_resp_valid}, 32'd1);
        chk("t4_idata", inst_resp_data, 32'h0000_1234);

        // Write with aw and w accepted in the same cycle
        data_req_valid = 1; data_req_wen = 1; data_addr = 32'h8000_2000;
        data_wdata = 32'h0BAD_F00D; data_wstrb = 4'b1111;
        settle();
        chk("t5_dready", {31'd0, data_req_ready}, 32'd1);
        tick();
        data_req_valid = 0; data_req_wen = 0; awready = 1; wready = 1;
        settle();
        chk("t5_wstrb", {28'd0, wstrb}, 32'hF);
        tick();
        awready = 0; wready = 0;
        settle();
        chk("t5_bready", {31'd0, bready}, 32'd1);
        chk("t5_awvalid", {31'd0, awvalid}, 32'd0);
        chk("t5_wvalid", {31'd0, wvalid}, 32'd0);
        bvalid = 1;
        tick();
        bvalid = 0;
        settle();
        chk("t5_dresp", {31'd0, data_resp_valid}, 32'd1);
        tick();

        // Reset in RD_DATA aborts the read
        inst_req_valid = 1; inst_addr = 32'hBFC0_0020;
        tick();
        inst_req_valid = 0; arready = 1;
        tick();
        arready = 0;
        settle();
        chk("t6_rready", {31'd0, rready}, 32'd1);
        reset = 1;
        tick();
        reset = 0; rvalid = 1; rid = 4'd0; rdata = 32'h5555_AAAA;
        settle();
        chk("t6_arvalid", {31'd0, arvalid}, 32'd0);
        chk("t6_rready_rst", {31'd0, rready}, 32'd0);
        chk("t6_iresp", {31'd0, inst_resp_valid}, 32'd0);
        tick();
        rvalid = 0;
        settle();
        chk("t6_iresp_late", {31'd0, inst_resp_valid}, 32'd0);
        inst_req_valid = 1; data_req_valid = 1; data_req_wen = 0;
        settle();
        chk("t6_idle_iready", {31'd0, inst_req_ready}, 32'd1);
        chk("t6_idle_dready", {31'd0, data_req_ready}, 32'd0);
        inst_req_valid = 0; data_req_valid = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
